// File: rtl/pp_fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for the pp_fifo_sync family.
// Address and count widths are derived here so every file agrees on them.
package pp_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 1024;

    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

    function automatic int addr_w(input int depth);
        return clog2(depth);
    endfunction

    // One extra bit so a completely full FIFO (count == DEPTH) is representable.
    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic bit params_ok(input int data_w, input int depth,
                                     input int af_level, input int ae_level);
        return (data_w >= 1) && (data_w <= 64) &&
               (depth >= 4) && ((depth & (depth - 1)) == 0) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/pp_fifo_sync_if.sv
// Handshake/status bundle between a FIFO (slave) and its producer/consumer (master).
// The read-data signal is called dout because "do" is a reserved word.
interface pp_fifo_sync_if
    import pp_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = cnt_w(DEF_DEPTH)
) ();
    logic              we;
    logic [DATA_W-1:0] di;
    logic              re;
    logic              clr_err;
    logic [DATA_W-1:0] dout;
    logic              empty_flag;
    logic              full_flag;
    logic              aempty_flag;
    logic              afull_flag;
    logic [CNT_W-1:0]  count;
    logic              ovf;
    logic              udf;

    modport master (
        output we, di, re, clr_err,
        input  dout, empty_flag, full_flag, aempty_flag, afull_flag, count, ovf, udf
    );

    modport slave (
        input  we, di, re, clr_err,
        output dout, empty_flag, full_flag, aempty_flag, afull_flag, count, ovf, udf
    );
endinterface

// File: rtl/pp_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
// A same-address read and write in one cycle returns the old word.
module pp_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/pp_fifo_sync.sv
// Parametrised single-clock FIFO with fill count, almost-full/empty and sticky error flags.
// Define PP_FIFO_FWFT_EN for first-word-fall-through; default build is registered-read mode.
module pp_fifo_sync
    import pp_fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 1024,
    parameter int AF_LEVEL = 1000,
    parameter int AE_LEVEL = 6
) (
    input logic             clk,
    input logic             rst,
    pp_fifo_sync_if.slave   bus
);
    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0]  AE_C    = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W:0]   PTR_ONE = (ADDR_W+1)'(1);

    generate
        if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
            $error("pp_fifo_sync: parameter out of range");
        end
    endgenerate

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d, full_q, full_d;
    logic              aempty_q, aempty_d, afull_q, afull_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              out_vld_q, out_vld_d;
    logic              rd_acc, wr_acc, ram_rd;
    logic [DATA_W-1:0] ram_q;
`ifdef PP_FIFO_FWFT_EN
    logic [CNT_W-1:0]  ram_cnt;
`endif

    always_comb begin
        rd_acc   = bus.re & ~empty_q;
        wr_acc   = bus.we & (~full_q | rd_acc);
        count_d  = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_acc && rd_acc) begin
            count_d = count_q - CNT_ONE;
        end
`ifdef PP_FIFO_FWFT_EN
        // The head word lives in the RAM read register; refill it whenever it is free or being taken.
        ram_cnt   = count_q - (out_vld_q ? CNT_ONE : '0);
        ram_rd    = (ram_cnt != '0) & (~out_vld_q | rd_acc);
        out_vld_d = ram_rd | (out_vld_q & ~rd_acc);
        empty_d   = ~out_vld_d;
`else
        ram_rd    = rd_acc;
        out_vld_d = out_vld_q | rd_acc;
        empty_d   = (count_d == '0);
`endif
        full_d   = (count_d == DEPTH_C);
        afull_d  = (count_d >= AF_C);
        aempty_d = (count_d <= AE_C);
        wr_ptr_d = wr_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = ram_rd ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        // A new error event outranks a clear arriving in the same cycle.
        ovf_d    = (ovf_q & ~bus.clr_err) | (bus.we & full_q & ~bus.re);
        udf_d    = (udf_q & ~bus.clr_err) | (bus.re & empty_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            aempty_q  <= 1'b1;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            aempty_q  <= aempty_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            out_vld_q <= out_vld_d;
        end
    end

    pp_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (bus.di),
        .re    (ram_rd),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (ram_q)
    );

    // Pointer wrap bits are kept for debug visibility; occupancy comes from count_q.
    logic unused_ptr_msb;
    assign unused_ptr_msb = wr_ptr_q[ADDR_W] ^ rd_ptr_q[ADDR_W];

    // RAM output has no reset, so mask it until it holds a word read since reset.
    assign bus.dout        = out_vld_q ? ram_q : '0;
    assign bus.empty_flag  = empty_q;
    assign bus.full_flag   = full_q;
    assign bus.aempty_flag = aempty_q;
    assign bus.afull_flag  = afull_q;
    assign bus.count       = count_q;
    assign bus.ovf         = ovf_q;
    assign bus.udf         = udf_q;
endmodule
